// File: rtl/ysyx_041514_bru_pkg.sv
// Shared configuration for the branch resolution unit: datapath width,
// default queue/RAS sizes, checkpoint payload layout and reset values.
package ysyx_041514_bru_pkg;

    localparam int unsigned XLEN          = 64;
    localparam int unsigned CKPT_DEPTH    = 4;
    localparam int unsigned RAS_DEPTH_DEF = 8;
    localparam int unsigned CNT_W         = 32;
    localparam int unsigned INSTR_BYTES   = 4;

    // Value redirect_pc_o holds until the first mispredict.
    localparam logic [XLEN-1:0]  RESET_PC = 64'h0;
    localparam logic [CNT_W-1:0] CNT_MAX  = 32'hFFFF_FFFF;

    // Prediction half of a checkpoint entry; the RAS pointer is appended
    // by the top because its width follows the RAS_DEPTH parameter.
    typedef struct packed {
        logic            pred_taken;
        logic [XLEN-1:0] pred_pc;
    } ckpt_pred_t;

    // Pointer width for a power-of-two structure, never narrower than one bit.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ysyx_041514_ckpt_fifo.sv
// In-order checkpoint queue: circular buffer with head/tail pointers and an
// occupancy count. clear empties the queue and wins over push/pop.
//   push/push_data : write one entry (ignored while full)
//   pop            : retire the head entry (ignored while empty)
//   head_data_c    : oldest entry, combinational read
//   full_c/empty_c : decoded from the registered count only
module ysyx_041514_ckpt_fifo
    import ysyx_041514_bru_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data_c,
    output logic             full_c,
    output logic             empty_c
);

    localparam int unsigned PTR_W = ptr_w(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_c      = (count_q == CNT_W'(DEPTH));
    assign empty_c     = (count_q == '0);
    assign head_data_c = mem[head_q];
    assign do_push     = push & ~full_c;
    assign do_pop      = pop & ~empty_c;

    // Next slot index with explicit wrap at DEPTH-1.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Pointer and occupancy state.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) tail_q <= ptr_inc(tail_q);
            if (do_pop)  head_q <= ptr_inc(head_q);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage needs no reset; only valid slots are ever read.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[tail_q] <= push_data;
    end

endmodule

// File: rtl/ysyx_041514_bru.sv
// Branch resolution unit. Checkpoints every IF prediction, compares the
// oldest one against the EX outcome and, on mismatch, issues a registered
// one-cycle redirect (restart PC + corrected RAS top pointer) and empties
// the checkpoint queue. Also keeps saturating resolve/mispredict counters.
//   enq_*          : prediction checkpoint from IF; enq_ready_o = !full
//   res_*          : actual outcome of the oldest in-flight instruction
//   flush_i        : external flush, empties the queue without a redirect
//   redirect_*     : mispredict redirect, valid one cycle after detection
//   underflow_err_o: sticky, resolve seen with an empty queue
//   resolve_cnt_o / mispred_cnt_o : saturating performance counters
module ysyx_041514_bru
    import ysyx_041514_bru_pkg::*;
#(
    parameter int unsigned DEPTH     = CKPT_DEPTH,
    parameter int unsigned RAS_DEPTH = RAS_DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enq_valid_i,
    output logic                          enq_ready_o,
    input  logic                          enq_pred_taken_i,
    input  logic [XLEN-1:0]               enq_pred_pc_i,
    input  logic [$clog2(RAS_DEPTH)-1:0]  enq_ras_ptr_i,
    input  logic                          res_valid_i,
    input  logic [XLEN-1:0]               res_pc_i,
    input  logic                          res_taken_i,
    input  logic [XLEN-1:0]               res_target_i,
    input  logic                          res_is_call_i,
    input  logic                          res_is_ret_i,
    input  logic                          flush_i,
    output logic                          redirect_valid_o,
    output logic [XLEN-1:0]               redirect_pc_o,
    output logic [$clog2(RAS_DEPTH)-1:0]  redirect_ras_ptr_o,
    output logic                          redirect_ras_ptr_valid_o,
    output logic                          underflow_err_o,
    output logic [CNT_W-1:0]              resolve_cnt_o,
    output logic [CNT_W-1:0]              mispred_cnt_o
);

    localparam int unsigned RAS_PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned ENTRY_W   = $bits(ckpt_pred_t) + RAS_PTR_W;

    ckpt_pred_t           enq_pred;
    logic [ENTRY_W-1:0]   enq_entry;
    logic [ENTRY_W-1:0]   head_data_c;
    ckpt_pred_t           head_pred;
    logic [RAS_PTR_W-1:0] head_ras_ptr;
    logic                 full_c;
    logic                 empty_c;
    logic                 push_c;
    logic                 deq_c;
    logic                 mispredict_c;
    logic                 kill_c;
    logic [XLEN-1:0]      restart_pc_c;
    logic [RAS_PTR_W-1:0] fixed_ras_ptr_c;

    logic                 redirect_valid_q;
    logic [XLEN-1:0]      redirect_pc_q;
    logic [RAS_PTR_W-1:0] redirect_ras_ptr_q;
    logic                 underflow_q;
    logic [CNT_W-1:0]     resolve_cnt_q;
    logic [CNT_W-1:0]     mispred_cnt_q;

    // Checkpoint packing.
    always_comb begin
        enq_pred            = '0;
        enq_pred.pred_taken = enq_pred_taken_i;
        enq_pred.pred_pc    = enq_pred_pc_i;
    end
    assign enq_entry                 = {enq_pred, enq_ras_ptr_i};
    assign {head_pred, head_ras_ptr} = head_data_c;

    // Queue control: readiness depends only on occupancy, never on res_*.
    assign enq_ready_o = ~full_c;
    assign deq_c       = res_valid_i & ~empty_c;
    assign kill_c      = mispredict_c | flush_i;
    assign push_c      = enq_valid_i & ~full_c & ~kill_c;

    ysyx_041514_ckpt_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_ckpt_fifo (
        .clk         (clk),
        .rst         (rst),
        .clear       (kill_c),
        .push        (push_c),
        .push_data   (enq_entry),
        .pop         (deq_c),
        .head_data_c (head_data_c),
        .full_c      (full_c),
        .empty_c     (empty_c)
    );

    // Direction mismatch, or correct "taken" with the wrong target.
    assign mispredict_c = deq_c &
                          ((head_pred.pred_taken != res_taken_i) |
                           (res_taken_i & (head_pred.pred_pc != res_target_i)));

    assign restart_pc_c = res_taken_i ? res_target_i
                                      : res_pc_i + XLEN'(INSTR_BYTES);

    // Replay this instruction's RAS effect on the checkpointed pointer.
    // call+ret is pop-then-push, so the net pointer movement is zero.
    always_comb begin
        fixed_ras_ptr_c = head_ras_ptr;
        if (res_is_call_i && !res_is_ret_i) begin
            fixed_ras_ptr_c = head_ras_ptr + RAS_PTR_W'(1);
        end else if (res_is_ret_i && !res_is_call_i) begin
            fixed_ras_ptr_c = head_ras_ptr - RAS_PTR_W'(1);
        end
    end

    // Redirect registers: pulse for one cycle, payload holds until next mispredict.
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_valid_q   <= 1'b0;
            redirect_pc_q      <= RESET_PC;
            redirect_ras_ptr_q <= '0;
        end else begin
            redirect_valid_q <= mispredict_c;
            if (mispredict_c) begin
                redirect_pc_q      <= restart_pc_c;
                redirect_ras_ptr_q <= fixed_ras_ptr_c;
            end
        end
    end

    // Sticky underflow flag and saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            underflow_q   <= 1'b0;
            resolve_cnt_q <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (res_valid_i && empty_c) underflow_q <= 1'b1;
            if (deq_c && (resolve_cnt_q != CNT_MAX)) begin
                resolve_cnt_q <= resolve_cnt_q + CNT_W'(1);
            end
            if (mispredict_c && (mispred_cnt_q != CNT_MAX)) begin
                mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
            end
        end
    end

    assign redirect_valid_o         = redirect_valid_q;
    assign redirect_pc_o            = redirect_pc_q;
    assign redirect_ras_ptr_o       = redirect_ras_ptr_q;
    assign redirect_ras_ptr_valid_o = redirect_valid_q;
    assign underflow_err_o          = underflow_q;
    assign resolve_cnt_o            = resolve_cnt_q;
    assign mispred_cnt_o            = mispred_cnt_q;

endmodule
